// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that shares one UART transmitter among
// NREQ byte-stream requesters. The grant is held until the byte flagged last
// has left the core, or until the granted requester stalls for TIMEOUT cycles.

// Per-requester slice: ready gating and data masking for the and-or mux.
module uart_tx_arb_lane #(
    parameter int DW = 8
) (
    input  logic          grant,
    input  logic          send_en,
    input  logic [DW-1:0] data,
    output logic          ready,
    output logic [DW-1:0] data_sel
);
    assign ready    = grant & send_en;
    assign data_sel = grant ? data : '0;
endmodule

module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      grant,
    output logic [DW-1:0]        tx_data,
    output logic                 tx_wr,
    input  logic                 tx_busy,
    output logic                 timeout
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

    state_t                     state;
    logic [IW-1:0]              ptr;
    logic                       last_q;
    logic                       guard;
    logic [CW-1:0]              stall_cnt;

    logic                       send_en;
    logic [NREQ-1:0][DW-1:0]    lane_data;
    logic [DW-1:0]              sel_data;
    logic                       g_valid;
    logic                       g_last;
    logic                       arb_found;
    logic [IW-1:0]              arb_idx;
    logic [IW-1:0]              cand;

    // Only the granted requester may hand over a byte, and only while the core is free.
    assign send_en = (state == SEND) && !tx_busy;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            uart_tx_arb_lane #(.DW(DW)) u_lane (
                .grant    (grant[gi]),
                .send_en  (send_en),
                .data     (req_data[gi*DW +: DW]),
                .ready    (req_ready[gi]),
                .data_sel (lane_data[gi])
            );
        end
    endgenerate

    // One-hot grant makes the OR of masked lanes a plain mux.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) sel_data = sel_data | lane_data[i];
        g_valid = |(req_valid & grant);
        g_last  = |(req_last & grant);
    end

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!arb_found && req_valid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Arbitration FSM with registered grant, strobe and timeout pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            grant     <= '0;
            tx_wr     <= 1'b0;
            tx_data   <= '0;
            timeout   <= 1'b0;
            stall_cnt <= '0;
            ptr       <= IW'(NREQ - 1);
            last_q    <= 1'b0;
            guard     <= 1'b0;
        end else begin
            tx_wr   <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        grant     <= NREQ'(1) << arb_idx;
                        ptr       <= arb_idx;
                        stall_cnt <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    // A busy core freezes both transfer and stall counting.
                    if (!tx_busy) begin
                        if (g_valid) begin
                            tx_wr     <= 1'b1;
                            tx_data   <= sel_data;
                            last_q    <= g_last;
                            stall_cnt <= '0;
                            guard     <= 1'b1;
                            state     <= HOLD;
                        end else if (stall_cnt >= CW'(TIMEOUT - 1)) begin
                            grant     <= '0;
                            timeout   <= 1'b1;
                            stall_cnt <= '0;
                            state     <= IDLE;
                        end else begin
                            stall_cnt <= stall_cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    // First hold cycle ignores tx_busy: the core may not have raised it yet.
                    if (guard) begin
                        guard <= 1'b0;
                    end else if (!tx_busy) begin
                        if (last_q) begin
                            grant <= '0;
                            state <= IDLE;
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: arbitration table, timeout and reset sequences,
// then a randomized run scored against packet queues and a round-robin model.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int DW = 8;
    localparam int TIMEOUT = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      grant;
    logic [DW-1:0]        tx_data;
    logic                 tx_wr;
    logic                 tx_busy;
    logic                 timeout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy), .timeout(timeout)
    );

    typedef struct packed {
        logic [NREQ-1:0] valid;
        logic [NREQ-1:0] exp_grant;
        logic [DW-1:0]   exp_data;
    } vec_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } byte_t;

    vec_t  tbl [8];
    byte_t sq [NREQ][$];
    byte_t eq [NREQ][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        tx_busy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_grant();
        for (int n = 0; n < 20 && grant == '0; n++) @(negedge clk);
    endtask

    task automatic wait_wr();
        for (int n = 0; n < 40 && !tx_wr; n++) @(negedge clk);
    endtask

    task automatic wait_release();
        for (int n = 0; n < 40 && grant != '0; n++) @(negedge clk);
    endtask

    initial begin
        int n, last_g, cur, exp_idx, busy_cnt, cyc, np, len, idx;
        bit pkt_open, done;
        logic [NREQ-1:0] prev_grant, prev_valid, hs;
        byte_t x;

        // Pointer starts at NREQ-1; each row advances it to the granted index.
        tbl[0] = '{4'b1111, 4'b0001, 8'hA0};
        tbl[1] = '{4'b1111, 4'b0010, 8'hA1};
        tbl[2] = '{4'b0101, 4'b0100, 8'hA2};
        tbl[3] = '{4'b0011, 4'b0001, 8'hA0};
        tbl[4] = '{4'b1000, 4'b1000, 8'hA3};
        tbl[5] = '{4'b1001, 4'b0001, 8'hA0};
        tbl[6] = '{4'b0001, 4'b0001, 8'hA0};
        tbl[7] = '{4'b1110, 4'b0010, 8'hA1};

        do_reset();
        check("rst_grant", 32'(grant), 0);
        check("rst_tx_wr", 32'(tx_wr), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_ready", 32'(req_ready), 0);

        // Single-byte packets, core never busy.
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 8'hA0 + 8'(i);
        for (int e = 0; e < 8; e++) begin
            @(negedge clk);
            req_valid = tbl[e].valid;
            req_last = '1;
            @(negedge clk);
            wait_grant();
            check("tbl_grant", 32'(grant), 32'(tbl[e].exp_grant));
            wait_wr();
            check("tbl_wr", 32'(tx_wr), 1);
            check("tbl_data", 32'(tx_data), 32'(tbl[e].exp_data));
            req_valid = '0;
            wait_release();
            check("tbl_release", 32'(grant), 0);
        end

        // Stalled mid-packet requester is force-released after TIMEOUT cycles in SEND.
        do_reset();
        req_valid = 4'b1000;
        req_data[3*DW +: DW] = 8'h55;
        req_last = '0;
        @(negedge clk);
        wait_grant();
        check("to_grant", 32'(grant), 32'(4'b1000));
        wait_wr();
        check("to_data", 32'(tx_data), 32'h55);
        req_valid = '0;
        n = 0;
        while (!timeout && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("to_delay", 32'(n), 32'(TIMEOUT + 2));
        check("to_grant_clr", 32'(grant), 0);
        @(negedge clk);
        check("to_pulse_width", 32'(timeout), 0);
        req_valid = '1;
        req_last = '1;
        @(negedge clk);
        wait_grant();
        check("to_next_r0", 32'(grant), 32'(4'b0001));
        wait_wr();
        req_valid = '0;
        wait_release();

        // Reset while holding for a busy core.
        do_reset();
        req_valid = 4'b0010;
        req_data[1*DW +: DW] = 8'h77;
        req_last = '0;
        @(negedge clk);
        wait_grant();
        wait_wr();
        tx_busy = 1'b1;
        req_valid = '0;
        @(negedge clk);
        check("hrst_held", 32'(grant), 32'(4'b0010));
        rst = 1'b0;
        @(negedge clk);
        check("hrst_grant", 32'(grant), 0);
        check("hrst_tx_wr", 32'(tx_wr), 0);
        check("hrst_ready", 32'(req_ready), 0);
        rst = 1'b1;
        tx_busy = 1'b0;
        req_valid = '1;
        req_last = '1;
        @(negedge clk);
        wait_grant();
        check("hrst_r0_first", 32'(grant), 32'(4'b0001));
        wait_wr();
        req_valid = '0;
        wait_release();

        // Randomized packets with random core busy time and spurious busy.
        do_reset();
        for (int r = 0; r < NREQ; r++) begin
            np = $urandom_range(1, 4);
            for (int p = 0; p < np; p++) begin
                len = $urandom_range(1, 3);
                for (int b = 0; b < len; b++) begin
                    x.d = DW'($urandom);
                    x.l = (b == len - 1);
                    sq[r].push_back(x);
                    eq[r].push_back(x);
                end
            end
        end
        last_g = NREQ - 1;
        cur = 0;
        pkt_open = 0;
        prev_grant = '0;
        prev_valid = '0;
        hs = '0;
        busy_cnt = 0;
        cyc = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            cyc++;
            for (int r = 0; r < NREQ; r++) if (hs[r]) x = sq[r].pop_front();
            check("rnd_onehot", 32'($onehot0(grant)), 1);
            if (prev_grant == '0 && grant != '0) begin
                exp_idx = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (last_g + k) % NREQ;
                    if (exp_idx < 0 && prev_valid[idx]) exp_idx = idx;
                end
                check("rnd_rr_grant", 32'(grant), (exp_idx < 0) ? 0 : (1 << exp_idx));
                if (exp_idx >= 0) begin
                    last_g = exp_idx;
                    cur = exp_idx;
                end
                pkt_open = 1;
            end else if (prev_grant != '0 && grant != prev_grant) begin
                check("rnd_release_grant", 32'(grant), 0);
                check("rnd_release_early", 32'(pkt_open), 0);
                pkt_open = 0;
            end
            if (tx_wr) begin
                check("rnd_wr_overlap", 32'(busy_cnt), 0);
                check("rnd_wr_grant", 32'(grant), 1 << cur);
                if (eq[cur].size() == 0) begin
                    check("rnd_extra_byte", 32'(tx_data), 32'hFFFF_FFFF);
                end else begin
                    x = eq[cur].pop_front();
                    check("rnd_data", 32'(tx_data), 32'(x.d));
                    if (x.l) pkt_open = 0;
                end
                busy_cnt = $urandom_range(1, 6);
            end
            check("rnd_no_timeout", 32'(timeout), 0);
            if (busy_cnt > 0) begin
                tx_busy = 1'b1;
                busy_cnt--;
            end else begin
                tx_busy = ($urandom_range(0, 7) == 0);
            end
            for (int r = 0; r < NREQ; r++) begin
                if (sq[r].size() > 0) begin
                    req_valid[r] = 1'b1;
                    req_data[r*DW +: DW] = sq[r][0].d;
                    req_last[r] = sq[r][0].l;
                end else begin
                    req_valid[r] = 1'b0;
                    req_data[r*DW +: DW] = DW'($urandom);
                    req_last[r] = 1'($urandom);
                end
            end
            prev_valid = req_valid;
            prev_grant = grant;
            #1;
            hs = req_valid & req_ready;
            check("rnd_ready_grant", 32'(req_ready & ~grant), 0);
            if (tx_busy) check("rnd_ready_busy", 32'(req_ready), 0);
            done = (grant == '0) && !tx_wr;
            for (int r = 0; r < NREQ; r++) if (eq[r].size() != 0) done = 0;
            if (!done && cyc > 5000) begin
                check("rnd_drain_budget", 32'(cyc), 0);
                done = 1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
